// File: rtl/st7789_spi_rx_pkg.sv
// ST7789 receive-side constants: opcodes shared with the transmitter init table, default window, decoder states.
// No logic; the cursor step helper is pure combinational.
package st7789_spi_rx_pkg;

  localparam logic [7:0] ST_SWRESET = 8'h01;
  localparam logic [7:0] ST_SLPOUT  = 8'h11;
  localparam logic [7:0] ST_COLMOD  = 8'h3A;
  localparam logic [7:0] ST_MADCTL  = 8'h36;
  localparam logic [7:0] ST_INVON   = 8'h21;
  localparam logic [7:0] ST_NORON   = 8'h13;
  localparam logic [7:0] ST_DISPON  = 8'h29;
  localparam logic [7:0] ST_DISPOFF = 8'h28;
  localparam logic [7:0] ST_CASET   = 8'h2A;
  localparam logic [7:0] ST_RASET   = 8'h2B;
  localparam logic [7:0] ST_RAMWR   = 8'h2C;

  localparam int DEF_WIDTH  = 240;
  localparam int DEF_HEIGHT = 240;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_RASET,
    S_RAMWR_HI,
    S_RAMWR_LO,
    S_SKIP
  } dec_state_t;

  // 8-bit cursor step: wraps to the window start once the end is reached
  function automatic logic [7:0] win_step(input logic [7:0] cur, input logic [7:0] lo,
                                          input logic [7:0] hi);
    return (cur == hi) ? lo : cur + 8'd1;
  endfunction

endpackage

// File: rtl/st7789_spi_byte_rx.sv
// SPI byte deserializer: synchronizes SCL/SDA/DC, samples SDA on SCL rise, drops stale partial bytes.
// Latency: byte_vld SYNC_STAGES+1 cycles after the 8th SCL rise; no backpressure (receive-only).
module st7789_spi_byte_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic       sda,
  input  logic       scl,
  input  logic       dc,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       byte_dc
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic [SS-1:0] scl_sync, sda_sync, dc_sync;
  logic          scl_prev;
  logic [6:0]    shreg;
  logic [2:0]    bitcnt;
  logic [TW-1:0] idle_cnt;
  logic          scl_s, sda_s, dc_s, rise, timeout;

  assign scl_s   = scl_sync[SS-1];
  assign sda_s   = sda_sync[SS-1];
  assign dc_s    = dc_sync[SS-1];
  assign rise    = scl_s & ~scl_prev;
  // the rise cycle itself is not part of the idle run
  assign timeout = scl_s & ~rise & (idle_cnt == TW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      scl_sync <= '1;
      sda_sync <= '0;
      dc_sync  <= '0;
      scl_prev <= 1'b1;
      shreg    <= '0;
      bitcnt   <= '0;
      idle_cnt <= '0;
      byte_vld <= 1'b0;
      byte_dat <= '0;
      byte_dc  <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SS-2:0], scl};
      sda_sync <= {sda_sync[SS-2:0], sda};
      dc_sync  <= {dc_sync[SS-2:0], dc};
      scl_prev <= scl_s;
      byte_vld <= 1'b0;

      if (!scl_s || rise)
        idle_cnt <= '0;
      else if (idle_cnt != TW'(IDLE_TIMEOUT))
        idle_cnt <= idle_cnt + TW'(1);

      if (rise) begin
        shreg  <= {shreg[5:0], sda_s};
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_dat <= {shreg, sda_s};
          byte_dc  <= dc_s;
        end
      end else if (timeout) begin
        bitcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/st7789_spi_rx.sv
// ST7789 command-stream decoder: CASET/RASET window, RAMWR pixel writes as {y,x}, display on/off, error flag.
// Latency: o_cmd_valid with o_byte_valid, o_px_we one cycle later; no backpressure (receive-only).
module st7789_spi_rx
  import st7789_spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int HEIGHT       = DEF_HEIGHT
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        i_sda,
  input  logic        i_scl,
  input  logic        i_dc,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte,
  output logic        o_byte_dc,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_px_we,
  output logic [15:0] o_px_adr,
  output logic [15:0] o_px_data,
  output logic        o_disp_on,
  output logic        o_err
);

  localparam logic [7:0] XE_RST = 8'(WIDTH - 1);
  localparam logic [7:0] YE_RST = 8'(HEIGHT - 1);

  logic [1:0] rst_sync;
  logic       rst_n;

  // asynchronous assert, synchronous release of the internal reset
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic       byte_vld, byte_dc, cmd_vld;
  logic [7:0] byte_dat;

  st7789_spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_byte_rx (
    .w_clk   (w_clk),
    .w_rst_n (rst_n),
    .sda     (i_sda),
    .scl     (i_scl),
    .dc      (i_dc),
    .byte_vld(byte_vld),
    .byte_dat(byte_dat),
    .byte_dc (byte_dc)
  );

  dec_state_t state;
  logic [1:0] pidx;
  logic [7:0] xs, xe, ys, ye, x, y, start_q, hi_q, cmd_q;

  assign cmd_vld      = byte_vld & ~byte_dc;
  assign o_byte_valid = byte_vld;
  assign o_byte       = byte_dat;
  assign o_byte_dc    = byte_dc;
  assign o_cmd_valid  = cmd_vld;
  // the opcode is visible in the same cycle as its strobe, then held
  assign o_cmd        = cmd_vld ? byte_dat : cmd_q;

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pidx      <= '0;
      xs        <= '0;
      xe        <= XE_RST;
      ys        <= '0;
      ye        <= YE_RST;
      x         <= '0;
      y         <= '0;
      start_q   <= '0;
      hi_q      <= '0;
      cmd_q     <= '0;
      o_px_we   <= 1'b0;
      o_px_adr  <= '0;
      o_px_data <= '0;
      o_disp_on <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_px_we <= 1'b0;
      if (byte_vld && !byte_dc) begin
        cmd_q <= byte_dat;
        pidx  <= '0;
        case (byte_dat)
          ST_CASET: state <= S_CASET;
          ST_RASET: state <= S_RASET;
          ST_RAMWR: begin
            state <= S_RAMWR_HI;
            x     <= xs;
            y     <= ys;
          end
          ST_SWRESET: begin
            state     <= S_IDLE;
            xs        <= '0;
            xe        <= XE_RST;
            ys        <= '0;
            ye        <= YE_RST;
            o_disp_on <= 1'b0;
          end
          ST_DISPON: begin
            state     <= S_SKIP;
            o_disp_on <= 1'b1;
          end
          ST_DISPOFF: begin
            state     <= S_SKIP;
            o_disp_on <= 1'b0;
          end
          default: state <= S_SKIP;
        endcase
      end else if (byte_vld) begin
        case (state)
          S_IDLE: o_err <= 1'b1;
          S_CASET, S_RASET: begin
            pidx <= pidx + 2'd1;
            // high bytes (p0, p2) are dropped: coordinates are 8-bit
            if (pidx == 2'd1) begin
              start_q <= byte_dat;
            end else if (pidx == 2'd3) begin
              if (state == S_CASET) begin
                xs <= start_q;
                xe <= byte_dat;
              end else begin
                ys <= start_q;
                ye <= byte_dat;
              end
              state <= S_IDLE;
            end
          end
          S_RAMWR_HI: begin
            hi_q  <= byte_dat;
            state <= S_RAMWR_LO;
          end
          S_RAMWR_LO: begin
            o_px_we   <= 1'b1;
            o_px_adr  <= {y, x};
            o_px_data <= {hi_q, byte_dat};
            x         <= win_step(x, xs, xe);
            if (x == xe) y <= win_step(y, ys, ye);
            state <= S_RAMWR_HI;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_st7789_spi_rx.sv
// Randomized SPI stimulus against a window/pixel-index reference model; scoreboard queues checked by a monitor.
module tb_st7789_spi_rx;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        i_sda = 1'b0;
  logic        i_scl = 1'b1;
  logic        i_dc = 1'b0;
  logic        o_byte_valid, o_byte_dc, o_cmd_valid, o_px_we, o_disp_on, o_err;
  logic [7:0]  o_byte, o_cmd;
  logic [15:0] o_px_adr, o_px_data;

  always #5 w_clk = ~w_clk;

  st7789_spi_rx dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .i_sda(i_sda), .i_scl(i_scl), .i_dc(i_dc),
    .o_byte_valid(o_byte_valid), .o_byte(o_byte), .o_byte_dc(o_byte_dc),
    .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_px_we(o_px_we),
    .o_px_adr(o_px_adr), .o_px_data(o_px_data), .o_disp_on(o_disp_on), .o_err(o_err)
  );

  int checks = 0;
  int failures = 0;

  logic [8:0]  exp_byte_q[$];
  logic [7:0]  exp_cmd_q[$];
  logic [31:0] exp_px_q[$];

  localparam int M_IDLE = 0, M_CASET = 1, M_RASET = 2, M_RAM = 3, M_SKIP = 4;
  int         m_xs, m_xe, m_ys, m_ye, m_mode, pix_n;
  int         prm[$];
  logic [7:0] m_hi;
  bit         m_have_hi, m_disp, m_err;
  bit         fast_mode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 239;
    m_mode = M_IDLE; pix_n = 0; prm.delete();
    m_have_hi = 0; m_disp = 0; m_err = 0;
  endtask

  // Reference: window takes effect after 4 params; pixel n of a RAMWR lands at start + n in raster order.
  task automatic model_byte(input bit dc, input logic [7:0] b);
    int w, h, xv, yv;
    exp_byte_q.push_back({dc, b});
    if (!dc) begin
      exp_cmd_q.push_back(b);
      prm.delete();
      m_have_hi = 0;
      case (b)
        8'h2A: m_mode = M_CASET;
        8'h2B: m_mode = M_RASET;
        8'h2C: begin m_mode = M_RAM; pix_n = 0; end
        8'h01: begin m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 239; m_disp = 0; m_mode = M_IDLE; end
        8'h29: begin m_disp = 1; m_mode = M_SKIP; end
        8'h28: begin m_disp = 0; m_mode = M_SKIP; end
        default: m_mode = M_SKIP;
      endcase
    end else begin
      case (m_mode)
        M_IDLE: m_err = 1;
        M_CASET, M_RASET: begin
          prm.push_back(int'(b));
          if (prm.size() == 4) begin
            if (m_mode == M_CASET) begin m_xs = prm[1]; m_xe = prm[3]; end
            else begin m_ys = prm[1]; m_ye = prm[3]; end
            prm.delete();
            m_mode = M_IDLE;
          end
        end
        M_RAM: begin
          if (!m_have_hi) begin
            m_hi = b; m_have_hi = 1;
          end else begin
            w = m_xe - m_xs + 1;
            h = m_ye - m_ys + 1;
            xv = m_xs + pix_n % w;
            yv = m_ys + (pix_n / w) % h;
            exp_px_q.push_back({8'(yv), 8'(xv), m_hi, b});
            pix_n++;
            m_have_hi = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  // All drives happen 1 time unit after a rising edge.
  task automatic send_bit(input bit dc, input bit b, input int lo, input int hi);
    i_scl = 1'b0; i_sda = b; i_dc = dc;
    repeat (lo) @(posedge w_clk);
    #1 i_scl = 1'b1;
    repeat (hi) @(posedge w_clk);
    #1;
  endtask

  function automatic int tlo();
    return fast_mode ? 2 : int'($urandom_range(4, 2));
  endfunction

  task automatic send_byte(input bit dc, input logic [7:0] b);
    int g;
    model_byte(dc, b);
    for (int i = 7; i >= 0; i--) send_bit(dc, b[i], tlo(), tlo());
    g = fast_mode ? 0 : int'($urandom_range(3, 0));
    if (g > 0) begin repeat (g) @(posedge w_clk); #1; end
  endtask

  task automatic send_pix(input logic [15:0] p);
    send_byte(1'b1, p[15:8]);
    send_byte(1'b1, p[7:0]);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_byte_q.size() + exp_cmd_q.size() + exp_px_q.size()) != 0 && n < 400) begin
      @(posedge w_clk); n++;
    end
    repeat (3) @(posedge w_clk);
    #1;
    chk({nm, "_pending"}, 64'(exp_byte_q.size() + exp_cmd_q.size() + exp_px_q.size()), 64'd0);
  endtask

  logic [8:0]  mon_b;
  logic [7:0]  mon_c;
  logic [31:0] mon_p;

  always @(negedge w_clk) begin
    if (w_rst_n) begin
      if (o_byte_valid) begin
        if (exp_byte_q.size() == 0) chk("byte_unexpected", {o_byte_dc, o_byte}, 64'h1_0000);
        else begin mon_b = exp_byte_q.pop_front(); chk("byte", {o_byte_dc, o_byte}, mon_b); end
      end
      if (o_cmd_valid) begin
        chk("cmd_with_byte", {o_byte_valid, o_byte_dc}, 2'b10);
        if (exp_cmd_q.size() == 0) chk("cmd_unexpected", o_cmd, 64'h1_0000);
        else begin mon_c = exp_cmd_q.pop_front(); chk("cmd", o_cmd, mon_c); end
      end
      if (o_px_we) begin
        if (exp_px_q.size() == 0) chk("px_unexpected", {o_px_adr, o_px_data}, 64'h1_0000_0000);
        else begin mon_p = exp_px_q.pop_front(); chk("px", {o_px_adr, o_px_data}, mon_p); end
      end
    end
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: run exceeded time limit checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  logic [8:0]  init_seq[9] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100, 9'h021, 9'h013, 9'h029};
  logic [15:0] pix_seq[5] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000};
  logic [7:0]  misc_cmd[5] = '{8'h36, 8'h3A, 8'h21, 8'h13, 8'h11};
  logic [7:0]  b8, lo8;

  initial begin
    model_reset();
    repeat (3) @(posedge w_clk);
    #1;
    chk("reset_outputs", {o_byte_valid, o_byte, o_byte_dc, o_cmd_valid, o_cmd, o_px_we,
                          o_px_adr, o_px_data, o_disp_on, o_err}, 64'd0);
    w_rst_n = 1'b1;
    repeat (4) @(posedge w_clk);
    #1;

    foreach (init_seq[i]) send_byte(init_seq[i][8], init_seq[i][7:0]);
    wait_drain("init");
    chk("init_disp_on", o_disp_on, m_disp);
    chk("init_err", o_err, m_err);

    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'd10); send_byte(1, 8'hAB); send_byte(1, 8'd12);
    send_byte(0, 8'h2B); send_byte(1, 8'h00); send_byte(1, 8'd20); send_byte(1, 8'h00); send_byte(1, 8'd21);
    send_byte(0, 8'h2C);
    foreach (pix_seq[i]) send_pix(pix_seq[i]);
    send_pix(16'($urandom));
    send_pix(16'($urandom));
    wait_drain("window");

    // half pixel then an aborted RASET: no write, window stays 10..12 x 20..21
    fast_mode = 1'b1;
    send_byte(0, 8'h2C); send_byte(1, 8'h12);
    send_byte(0, 8'h2B); send_byte(1, 8'h00); send_byte(1, 8'h50);
    send_byte(0, 8'h2C);
    send_pix(16'($urandom)); send_pix(16'($urandom)); send_pix(16'($urandom)); send_pix(16'($urandom));
    wait_drain("abort");
    fast_mode = 1'b0;

    for (int r = 0; r < 4; r++) begin
      fast_mode = r[0];
      b8 = 8'($urandom_range(250, 0));
      lo8 = b8 + 8'($urandom_range(4, 0));
      send_byte(0, 8'h2A); send_byte(1, 8'($urandom)); send_byte(1, b8);
      send_byte(1, 8'($urandom)); send_byte(1, lo8);
      b8 = 8'($urandom_range(250, 0));
      lo8 = b8 + 8'($urandom_range(3, 0));
      send_byte(0, 8'h2B); send_byte(1, 8'($urandom)); send_byte(1, b8);
      send_byte(1, 8'($urandom)); send_byte(1, lo8);
      send_byte(0, misc_cmd[$urandom_range(4, 0)]); send_byte(1, 8'($urandom));
      send_byte(0, 8'h29);
      send_byte(0, 8'h2C);
      for (int p = 0; p < int'($urandom_range(14, 5)); p++) send_pix(16'($urandom));
      send_byte(1, 8'($urandom));
      send_byte(0, 8'h28);
      wait_drain("rand_win");
      chk("rand_disp_off", o_disp_on, m_disp);
    end
    fast_mode = 1'b0;

    // 5 stray bits, SCL high for 64 idle cycles after the last rise: partial byte dropped
    for (int i = 0; i < 5; i++) send_bit(1, 1'($urandom), 2, (i == 4) ? 65 : 2);
    send_byte(0, 8'h2C);
    wait_drain("timeout_drop");
    chk("timeout_drop_cmd", o_cmd, 8'h2C);

    // 63 idle cycles: the partial byte survives and completes as 0x29
    model_byte(0, 8'h29);
    b8 = 8'h29;
    for (int i = 7; i >= 0; i--) send_bit(0, b8[i], 2, (i == 3) ? 64 : 2);
    wait_drain("timeout_keep");
    chk("timeout_keep_disp", o_disp_on, m_disp);

    send_byte(0, 8'h01);
    send_byte(0, 8'h2C);
    send_pix(16'($urandom)); send_pix(16'($urandom)); send_pix(16'($urandom));
    send_byte(0, 8'h01);
    send_byte(1, 8'h5A);
    wait_drain("swreset");
    chk("idle_data_err", o_err, m_err);
    chk("swreset_disp", o_disp_on, m_disp);

    send_byte(0, 8'h29);
    wait_drain("pre_arst");
    for (int i = 0; i < 4; i++) send_bit(1, 1'($urandom), 2, 2);
    i_scl = 1'b0;
    @(posedge w_clk);
    #3 w_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {o_byte_valid, o_byte, o_byte_dc, o_cmd_valid, o_cmd, o_px_we,
                                o_px_adr, o_px_data, o_disp_on, o_err}, 64'd0);
    model_reset();
    i_scl = 1'b1;
    repeat (3) @(posedge w_clk);
    #1 w_rst_n = 1'b1;
    repeat (4) @(posedge w_clk);
    #1;
    send_byte(0, 8'h29);
    send_byte(0, 8'h2C);
    send_pix(16'($urandom)); send_pix(16'($urandom));
    wait_drain("post_arst");
    chk("post_arst_disp", o_disp_on, m_disp);
    chk("post_arst_err", o_err, m_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
